tick_bcd_counter: RTL

- Consumes the slow divided-clock level from the ripple clock divider and converts each of its rising edges into a one-cycle enable in the system `clock` domain.
- Uses that enable to advance a 4-digit BCD counter with run and clear controls.
- Time-multiplexes the four digits onto a shared active-low seven-segment bus for the board display.
- All logic runs on the single `clock`; `div_clock` is treated as an asynchronous data input, never as a clock.

---
 rtl/tick_bcd_counter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter
// Turns rising edges of an asynchronous divided-clock level into one-cycle
// ticks in the system clock domain, counts those ticks on a 4-digit BCD
// counter, and scans the four digits onto an active-low seven-segment bus.
module tick_bcd_counter #(
    parameter int SCAN_BITS = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_clock,
    input  logic        run,
    input  logic        clear,
    output logic        tick,
    output logic [15:0] count,
    output logic        rollover,
    output logic [3:0]  anode,
    output logic [6:0]  seg
);

    // Synchronizer (sync_p0, sync_p1) plus one edge-detect stage (sync_p2)
    logic                 sync_p0;
    logic                 sync_p1;
    logic                 sync_p2;

    logic [15:0]          count_q;
    logic                 rollover_q;
    logic [16:0]          inc_res;

    logic [SCAN_BITS-1:0] scan_q;
    logic [1:0]           sel;
    logic [3:0]           cur_digit;

    // BCD increment of all four digits; bit 16 flags the 9999 -> 0000 wrap.
    function automatic logic [16:0] bcd_inc(input logic [15:0] value);
        logic [15:0] res;
        logic        carry;
        res   = value;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] >= 4'd9) begin
                    // A digit at 9 wraps and carries; >= keeps digits in 0..9
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return {carry, res};
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; blank otherwise.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Stage p0..p2: bring div_clock into the clock domain and keep history for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= div_clock;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Rising edge of the synchronized level; falling edges are ignored
    assign tick = sync_p1 & ~sync_p2;

    assign inc_res = bcd_inc(count_q);

    // Count update: clear wins over a tick, ticks without run are dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= 16'h0000;
            rollover_q <= 1'b0;
        end else if (clear) begin
            count_q    <= 16'h0000;
            rollover_q <= 1'b0;
        end else if (tick && run) begin
            count_q    <= inc_res[15:0];
            rollover_q <= inc_res[16];
        end else begin
            rollover_q <= 1'b0;
        end
    end

    assign count    = count_q;
    assign rollover = rollover_q;

    // Free-running scan counter; its top two bits pick the displayed digit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    assign sel = scan_q[SCAN_BITS-1 -: 2];

    // Digit multiplexer feeding the shared segment decoder
    always_comb begin
        cur_digit = count_q[3:0];
        case (sel)
            2'd0: cur_digit = count_q[3:0];
            2'd1: cur_digit = count_q[7:4];
            2'd2: cur_digit = count_q[11:8];
            2'd3: cur_digit = count_q[15:12];
            default: cur_digit = count_q[3:0];
        endcase
    end

    assign anode = ~(4'b0001 << sel);
    assign seg   = seg_decode(cur_digit);

endmodule
